// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (port 0 CPU, port 1 loader).
// Latency: grant in IDLE cycle k, memory access in k+1, response strobe in k+2; one access per 3 cycles.
// Backpressure: requesters hold req until gnt; nothing is granted while busy; port 1 is forced after STARVE_MAX losses.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DEPTH      = 100,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);
    localparam int IW = AW - 2;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] DEPTH_LIM  = AW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;

    // Access captured at grant time and replayed in ACCESS/RESP
    logic          lat_port;
    logic          lat_we;
    logic          lat_err;
    logic [IW-1:0] lat_idx;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] resp_data;

    // Winner-side view of the request lines
    logic          any_req;
    logic          sel_p1;
    logic          win_we;
    logic          win_err;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [IW-1:0] win_idx;

    // Arbitration and address decode of the winning request (only acted on in IDLE)
    always_comb begin
        any_req   = p0_req | p1_req;
        sel_p1    = p1_req & (~p0_req | (starve_cnt == STARVE_LIM));
        win_we    = sel_p1 ? p1_we    : p0_we;
        win_addr  = sel_p1 ? p1_addr  : p0_addr;
        win_wdata = sel_p1 ? p1_wdata : p0_wdata;
        win_idx   = win_addr[AW-1:2];
        // Range check on the zero-extended full index so no high bits are lost
        win_err   = (win_addr[1:0] != 2'b00) | ({2'b00, win_idx} >= DEPTH_LIM);
    end

    // Next-state, grants and memory-side drive
    always_comb begin
        state_nxt = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    p0_gnt    = ~sel_p1;
                    p1_gnt    = sel_p1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr  = lat_err ? '0 : {2'b00, lat_idx};
                mem_wd    = lat_wdata;
                mem_we    = lat_we & ~lat_err;
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Response strobes steered to the owning port only; the other port reads all zeros
    always_comb begin
        busy      = (state != IDLE);
        p0_rvalid = (state == RESP) & ~lat_port;
        p1_rvalid = (state == RESP) &  lat_port;
        p0_err    = p0_rvalid & lat_err;
        p1_err    = p1_rvalid & lat_err;
        p0_rdata  = p0_rvalid ? resp_data : '0;
        p1_rdata  = p1_rvalid ? resp_data : '0;
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winning request on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            lat_port  <= sel_p1;
            lat_we    <= win_we;
            lat_err   <= win_err;
            lat_idx   <= win_idx;
            lat_wdata <= win_wdata;
        end
    end

    // Register read data at the end of ACCESS; writes and rejected accesses return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data <= '0;
        end else if (state == ACCESS) begin
            resp_data <= (lat_we | lat_err) ? '0 : mem_rd;
        end
    end

    // Count consecutive IDLE-cycle losses by port 1; saturates at the forcing threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (p1_gnt || !p1_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, reference memory model and response scoreboard.
// Latency: expectations pushed at grant, popped when rvalid appears two cycles later.
// Backpressure: requests held until gnt with bounded waits; expired waits count as failures.
module tb_dmem_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int DEPTH      = 100;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic          port;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          p0_req   = 1'b0;
    logic          p0_we    = 1'b0;
    logic [AW-1:0] p0_addr  = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req   = 1'b0;
    logic          p1_we    = 1'b0;
    logic [AW-1:0] p1_addr  = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;
    logic          busy;

    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            we_cnt = 0;

    exp_t          mon_e;
    logic [1:0]    mon_v;
    logic          mon_err;
    logic          mon_oerr;
    logic [DW-1:0] mon_rd;
    logic [DW-1:0] mon_ord;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on rising edge
    assign mem_rd = (mem_addr < 32'd100) ? mem[mem_addr[6:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we === 1'b1) begin
            we_cnt <= we_cnt + 1;
            if (mem_addr < 32'd100) mem[mem_addr[6:0]] <= mem_wd;
        end
    end

    // Reference prediction of one access; applies legal writes to the reference memory
    function automatic exp_t predict(input logic port, input logic we,
                                     input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t          e;
        logic [AW-1:0] idx;
        idx     = addr >> 2;
        e.port  = port;
        e.err   = (addr[1:0] != 2'b00) || (idx >= 32'd100);
        e.rdata = '0;
        if (!e.err) begin
            if (we) ref_mem[idx[6:0]] = wd;
            else    e.rdata = ref_mem[idx[6:0]];
        end
        return e;
    endfunction

    // Response scoreboard and one-grant-per-cycle monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (p0_gnt === 1'b1 || p1_gnt === 1'b1) begin
                checks++;
                if (p0_gnt === 1'b1 && p1_gnt === 1'b1) begin
                    errors++;
                    $display("FAIL dual_gnt: cycle %0d p0_gnt=1 p1_gnt=1, required at most one", cyc);
                end
            end
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid: cycle %0d p0_rvalid=%b p1_rvalid=%b, required none",
                             cyc, p0_rvalid, p1_rvalid);
                end else begin
                    mon_e    = sbq.pop_front();
                    mon_v    = {p1_rvalid, p0_rvalid};
                    mon_err  = mon_e.port ? p1_err   : p0_err;
                    mon_rd   = mon_e.port ? p1_rdata : p0_rdata;
                    mon_oerr = mon_e.port ? p0_err   : p1_err;
                    mon_ord  = mon_e.port ? p0_rdata : p1_rdata;
                    if (mon_v !== (mon_e.port ? 2'b10 : 2'b01) || mon_err !== mon_e.err ||
                        mon_rd !== mon_e.rdata || mon_oerr !== 1'b0 || mon_ord !== '0) begin
                        errors++;
                        $display("FAIL response: cycle %0d rvalid=%b err=%b rdata=%h other_err=%b other_rdata=%h, required port%0d err=%b rdata=%h other zero",
                                 cyc, mon_v, mon_err, mon_rd, mon_oerr, mon_ord, mon_e.port, mon_e.err, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end
    endtask

    // One complete access; reports memory-side drive in k+1 and the port's response in k+2
    task automatic access(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int gcyc, output logic a_we,
                          output logic [AW-1:0] a_addr, output logic rv,
                          output logic [DW-1:0] rd, output logic oth);
        drive(port, 1'b1, we, addr, wd);
        gcyc = -1; a_we = 1'b0; a_addr = '0; rv = 1'b0; rd = '0; oth = 1'b0;
        for (int i = 0; i < 20 && gcyc < 0; i++) begin
            @(negedge clk);
            if ((port ? p1_gnt : p0_gnt) === 1'b1) begin
                gcyc = cyc;
                sbq.push_back(predict(port, we, addr, wd));
            end
        end
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, '0, '0);
        checks++;
        if (gcyc < 0) begin
            errors++;
            $display("FAIL gnt_timeout: port %0d not granted within 20 cycles, required grant", port);
        end else begin
            @(negedge clk);
            a_we = mem_we; a_addr = mem_addr;
            @(negedge clk);
            rv  = port ? p1_rvalid : p0_rvalid;
            rd  = port ? p1_rdata  : p0_rdata;
            oth = port ? (p0_rvalid | (|p0_rdata)) : (p1_rvalid | (|p1_rdata));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, busy, mem_we} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: gnt/rvalid/err/busy/we=%b, required 00000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, busy, mem_we});
        end
        checks++;
        if (p0_rdata !== '0 || p1_rdata !== '0 || mem_addr !== '0 || mem_wd !== '0) begin
            errors++;
            $display("FAIL reset_buses: p0_rdata=%h p1_rdata=%h mem_addr=%h mem_wd=%h, required 0",
                     p0_rdata, p1_rdata, mem_addr, mem_wd);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int g; logic aw; logic [AW-1:0] aa; logic rv; logic [DW-1:0] rd; logic oth;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, g, aw, aa, rv, rd, oth);
        checks++;
        if (aw !== 1'b1 || aa !== 32'd4) begin
            errors++;
            $display("FAIL wr_mem_drive: mem_we=%b mem_addr=%0d, required 1 and 4", aw, aa);
        end
        checks++;
        if (rv !== 1'b1 || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_commit: rvalid=%b mem[4]=%h, required 1 and deadbeef", rv, mem[4]);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, g, aw, aa, rv, rd, oth);
        checks++;
        if (aw !== 1'b0 || aa !== 32'd4 || rv !== 1'b1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: mem_we=%b mem_addr=%0d rvalid=%b rdata=%h, required 0 4 1 deadbeef",
                     aw, aa, rv, rd);
        end
    endtask

    task automatic test_errors();
        int g; int wc; logic aw; logic [AW-1:0] aa; logic rv; logic [DW-1:0] rd; logic oth;
        wc = we_cnt;
        access(1'b1, 1'b1, 32'd400, 32'hBAD0BAD0, g, aw, aa, rv, rd, oth);
        checks++;
        if (aw !== 1'b0 || aa !== '0) begin
            errors++;
            $display("FAIL oor_write: mem_we=%b mem_addr=%0d, required 0 and 0", aw, aa);
        end
        access(1'b1, 1'b0, 32'h6, 32'h0, g, aw, aa, rv, rd, oth);
        access(1'b1, 1'b1, 32'h11, 32'h55555555, g, aw, aa, rv, rd, oth);
        checks++;
        if (we_cnt !== wc || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL err_no_write: writes=%0d mem[4]=%h, required %0d and deadbeef", we_cnt, mem[4], wc);
        end
        access(1'b1, 1'b1, 32'd396, 32'hC0FFEE99, g, aw, aa, rv, rd, oth);
        checks++;
        if (aw !== 1'b1 || aa !== 32'd99) begin
            errors++;
            $display("FAIL idx99_write: mem_we=%b mem_addr=%0d, required 1 and 99", aw, aa);
        end
        access(1'b1, 1'b0, 32'd396, 32'h0, g, aw, aa, rv, rd, oth);
        checks++;
        if (rv !== 1'b1 || rd !== 32'hC0FFEE99) begin
            errors++;
            $display("FAIL idx99_read: rvalid=%b rdata=%h, required 1 and c0ffee99", rv, rd);
        end
    endtask

    task automatic test_isolation();
        int g; logic aw; logic [AW-1:0] aa; logic rv; logic [DW-1:0] rd; logic oth;
        access(1'b1, 1'b0, 32'hC, 32'h0, g, aw, aa, rv, rd, oth);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h1234 || oth !== 1'b0) begin
            errors++;
            $display("FAIL isolation: p1_rvalid=%b p1_rdata=%h p0_activity=%b, required 1 1234 0", rv, rd, oth);
        end
    endtask

    task automatic test_starvation();
        int gc; int prev; logic gp; logic exp_p;
        prev = -1;
        drive(1'b0, 1'b1, 1'b0, 32'h20, '0);
        drive(1'b1, 1'b1, 1'b0, 32'h24, '0);
        for (int g = 0; g < 10; g++) begin
            gc = -1; gp = 1'b0;
            for (int i = 0; i < 8 && gc < 0; i++) begin
                @(negedge clk);
                if (p0_gnt === 1'b1 || p1_gnt === 1'b1) begin
                    gc = cyc; gp = p1_gnt;
                end
            end
            exp_p = (g % 5 == 4);
            checks++;
            if (gc < 0) begin
                errors++;
                $display("FAIL starve_timeout: grant %0d missing, required port%0d", g, exp_p);
            end else begin
                if (gp !== exp_p) begin
                    errors++;
                    $display("FAIL starve_order: grant %0d went to port%0d, required port%0d", g, gp, exp_p);
                end
                sbq.push_back(predict(gp, 1'b0, gp ? 32'h24 : 32'h20, '0));
                if (prev >= 0) begin
                    checks++;
                    if (gc - prev != 3) begin
                        errors++;
                        $display("FAIL gnt_spacing: %0d cycles between grants, required 3", gc - prev);
                    end
                end
                prev = gc;
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_busy_req();
        int k;
        k = -1;
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hA5A55A5A);
        for (int i = 0; i < 8 && k < 0; i++) begin
            @(negedge clk);
            if (p0_gnt === 1'b1) begin
                k = cyc;
                sbq.push_back(predict(1'b0, 1'b1, 32'h30, 32'hA5A55A5A));
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h30, '0);
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b0 || p0_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_gnt: p1_gnt=%b p0_rvalid=%b in RESP, required 0 and 1", p1_gnt, p0_rvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b1 || cyc != k + 3) begin
            errors++;
            $display("FAIL busy_regrant: p1_gnt=%b at cycle offset %0d, required 1 at 3", p1_gnt, cyc - k);
        end else begin
            sbq.push_back(predict(1'b1, 1'b0, 32'h30, '0));
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA5A55A5A) begin
            errors++;
            $display("FAIL busy_resp: p1_rvalid=%b p1_rdata=%h two cycles after grant, required 1 a5a55a5a",
                     p1_rvalid, p1_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int k;
        k = -1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
        drive(1'b1, 1'b1, 1'b0, 32'h24, '0);
        for (int i = 0; i < 8 && k < 0; i++) begin
            @(negedge clk);
            if (p0_gnt === 1'b1 || p1_gnt === 1'b1) k = cyc;
        end
        checks++;
        if (k < 0 || p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: p0_gnt=%b p1_gnt=%b, required p0 grant", p0_gnt, p1_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || p0_rvalid !== 1'b0 || mem_we !== 1'b0 || dut.starve_cnt !== '0) begin
            errors++;
            $display("FAIL rstmid_idle: busy=%b p0_rvalid=%b mem_we=%b starve_cnt=%0d, required all 0",
                     busy, p0_rvalid, mem_we, dut.starve_cnt);
        end
        @(negedge clk);
        checks++;
        if (p0_rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_dropped: p0_rvalid=%b busy=%b, required 0 0", p0_rvalid, busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[3]     = 32'h1234;
        ref_mem[3] = 32'h1234;
        test_reset();
        test_basic();
        test_errors();
        test_isolation();
        test_starvation();
        test_busy_req();
        test_reset_mid();
        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: %0d responses outstanding, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. Shares the memory between the CPU load/store path (port 0) and the program/debug loader (port 1). Each access runs a fixed IDLE→ACCESS→RESP sequence: it converts byte addresses to word indices, guards against out-of-range or misaligned accesses, and returns registered read data with a one-cycle response strobe.

## Interface
- `AW`, 32, address width (byte address)
- `DW`, 32, data width
- `DEPTH`, 100, memory depth in words
- `STARVE_MAX`, 4, consecutive lost arbitrations after which port 1 wins (≥1)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `p0_req`, `p1_req`  in  1  access request, held until granted
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  AW  byte address
- `p0_wdata`, `p1_wdata`  in  DW  write data
- `p0_gnt`, `p1_gnt`  out  1  request accepted this cycle (combinational, IDLE only)
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle response strobe (reads and writes)
- `p0_rdata`, `p1_rdata`  out  DW  read data, valid with rvalid
- `p0_err`, `p1_err`  out  1  access rejected, valid with rvalid
- `mem_addr`  out  AW  word index to memory
- `mem_wd`  out  DW  write data to memory
- `mem_we`  out  1  write enable to memory
- `mem_rd`  in  DW  memory read data (combinational from `mem_addr`)
- `busy`  out  1  high in ACCESS and RESP

## Operation
- **FSM:** IDLE, ACCESS, RESP.
- **IDLE, no requests:** stay in IDLE.
- **IDLE, any request:**
  - Pick a winner and assert its gnt combinationally.
  - Latch port id, we, wdata, word index = addr[AW-1:2], and err.
  - err = (addr[1:0] != 0) or (index ≥ DEPTH).
  - Next state is ACCESS.
- **Arbitration:**
  - Port 0 wins by default.
  - Port 1 wins alone, or when starve_cnt == STARVE_MAX.
  - starve_cnt increments (saturating) each IDLE cycle where p1_req is high and p1 is not granted.
  - starve_cnt clears when p1 is granted or when p1_req is low in IDLE.
- **ACCESS:**
  - mem_addr = latched index (0 if err); mem_wd = latched wdata.
  - mem_we = latched we & !err.
  - Capture mem_rd into the response register (0 if write or err).
  - Next state is RESP.
- **RESP:**
  - Assert rvalid and err for the latched port only; the other port's outputs stay 0.
  - mem_we = 0. Next state is IDLE.
- **Outside ACCESS:** mem_addr, mem_wd and mem_we are 0.
- **Requester rules:** hold req/we/addr/wdata stable until gnt. A new request may be raised the cycle after rvalid.

## Timing
- **Reset values:**
  - State IDLE, starve_cnt 0.
  - All gnt, rvalid, err and busy = 0.
  - All rdata = 0.
  - mem_addr, mem_wd and mem_we = 0.
- **Latency:** request granted in cycle k (IDLE) → mem_we / mem_addr driven in cycle k+1 → rvalid in cycle k+2.
- **Memory write:** commits at the rising edge ending cycle k+1.
- **Throughput:** one access per 3 cycles. Back-to-back requests are re-granted in cycle k+3.
- **Requests outside IDLE:** not granted; gnt stays 0.
- **Simultaneous requests:** exactly one gnt per cycle, never both.
- **Reset mid-operation:** rst at any edge forces IDLE. The pending access is dropped, no rvalid is issued, and mem_we is 0 in the following cycle. A write already committed at that edge stays committed.
- **Rejected access (err):** no memory write occurs, rdata = 0, err = 1 with rvalid.
- **Index check:** compare at full AW-2 width, with no truncation. Index 99 is legal; index 100 is an error.

## Test plan
- **Basic write then read:** p0 writes 0xDEADBEEF to addr 0x10, then reads 0x10. Required: mem_we=1 with mem_addr=4 in cycle k+1; p0_rvalid at k+2 with err=0; the read returns 0xDEADBEEF at its k+2.
- **Out-of-range and misaligned:** p1 writes addr 400 (index 100), then reads addr 0x6. Required: both responses have err=1, rdata=0, and mem_we never asserted.
- **Starvation guard:** p0_req and p1_req held continuously with STARVE_MAX=4. Required: grants run p0 ×4, p1 ×1, repeating; never two gnt in one cycle.
- **Port isolation:** p1 read of index 3 holding 0x1234. Required: p1_rvalid=1 with rdata=0x1234; p0_rvalid=0 and p0_rdata=0 in that cycle.
- **Reset mid-access:** rst=1 in the ACCESS cycle of a p0 read. Required: no p0_rvalid, state IDLE, busy=0 next cycle, starve_cnt=0.
- **Request during busy:** p1_req rises in the RESP cycle of a p0 access. Required: p1_gnt only in the next IDLE cycle, with its response 2 cycles later.
